// File: rtl/deco4_arb_pkg.sv
// Shared types and the rotate-priority pick function for the deco4 sharing arbiter.
// Supports up to 8 requesters; wider requester counts need a larger index field.
package deco4_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 4;
  localparam int OW_DEF   = 8;
  localparam int MAXREQ   = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // The loop runs from the far end of the scan back toward ptr. Each hit
  // overwrites the previous one, so the first requester in scan order wins.
  function automatic pick_t rr_pick(input logic [MAXREQ-1:0] req,
                                    input logic [2:0]        ptr,
                                    input logic [3:0]        nreq);
    pick_t      p;
    logic [3:0] idx;
    p = '0;
    for (int k = MAXREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= nreq) idx = idx - nreq;
      if ((4'(k) < nreq) && req[idx[2:0]]) begin
        p.found = 1'b1;
        p.idx   = idx[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/deco4_share_arb_rr_picker.sv
// Combinational rotate-priority encoder.
// Returns the first active request found scanning from i_ptr upward, wrapping modulo NREQ.
module rr_picker
  import deco4_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = $clog2(NREQ_DEF)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic            o_found,
  output logic [PW-1:0]   o_idx
);

  logic [MAXREQ-1:0] w_req;
  pick_t             w_pick;

  always_comb begin
    w_req             = '0;
    w_req[NREQ-1:0]   = i_req;
    w_pick            = rr_pick(w_req, 3'(i_ptr), 4'(NREQ));
  end

  assign o_found = w_pick.found;
  assign o_idx   = PW'(w_pick.idx);

endmodule

// File: rtl/deco4_share_arb.sv
// Time-shares one external combinational deco4 among NREQ requesters.
// Arbitration is round-robin; each result is stored in that requester's own slot.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no transaction; wait for any req
//   SETUP   | pick winner, register dec_a and pulse gnt
//   CAPTURE | sample dec_b into winner's slot, pulse rsp_valid, advance rr_ptr
module deco4_share_arb
  import deco4_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int OW   = OW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   din,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        dec_a,
  input  logic [OW-1:0]        dec_b,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [NREQ*OW-1:0]   rsp_data,
  output logic                 busy
);

  localparam int PW = $clog2(NREQ);
  localparam logic [NREQ-1:0] LSB_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NREQ-1:0]     r_gnt;
  logic [NREQ-1:0]     r_rsp_valid;
  logic [DW-1:0]       r_dec_a;
  logic [NREQ*OW-1:0]  r_rsp_data;
  logic [PW-1:0]       r_rr_ptr;
  logic [PW-1:0]       r_cur;

  logic                w_found;
  logic [PW-1:0]       w_win;
  logic [PW-1:0]       w_ptr_nxt;
  logic [NREQ-1:0]     w_cur_mask;
  logic [NREQ-1:0]     w_req_others;

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .i_req   (req),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  // During CAPTURE the winner's req is still high. Mask it so that this
  // stale level does not start a second grant to the same requester.
  assign w_cur_mask   = LSB_ONE << r_cur;
  assign w_req_others = req & ~w_cur_mask;
  assign w_ptr_nxt    = (r_cur == PW'(NREQ - 1)) ? '0 : r_cur + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|req) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = w_found ? CAPTURE : IDLE;
      CAPTURE: w_state_nxt = (|w_req_others) ? SETUP : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_dec_a     <= '0;
      r_rsp_data  <= '0;
      r_rr_ptr    <= '0;
      r_cur       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      if (r_state == SETUP && w_found) begin
        r_dec_a <= din[w_win*DW +: DW];
        r_gnt   <= LSB_ONE << w_win;
        r_cur   <= w_win;
      end
      if (r_state == CAPTURE) begin
        r_rsp_data[r_cur*OW +: OW] <= dec_b;
        r_rsp_valid                <= w_cur_mask;
        r_rr_ptr                   <= w_ptr_nxt;
      end
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign dec_a     = r_dec_a;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_deco4_share_arb.sv
// Directed and randomized checks of deco4_share_arb against a 7-segment deco4 model
// and a transaction-level round-robin scoreboard.
module tb_deco4_share_arb;

  localparam int NREQ  = 4;
  localparam int DW    = 4;
  localparam int OW    = 8;
  localparam int BOUND = 2 * NREQ + 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  din;
  logic [NREQ-1:0]     gnt;
  logic [DW-1:0]       dec_a;
  logic [OW-1:0]       dec_b;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ*OW-1:0]  rsp_data;
  logic                busy;

  int errors = 0;
  int checks = 0;
  logic [OW-1:0] exp_slot [NREQ];

  deco4_share_arb #(.NREQ(NREQ), .DW(DW), .OW(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .dec_a     (dec_a),
    .dec_b     (dec_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
      4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
      4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
      4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
    endcase
  endfunction

  assign dec_b = seg7(dec_a);

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic logic [NREQ*OW-1:0] exp_vec();
    logic [NREQ*OW-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i*OW +: OW] = exp_slot[i];
    return v;
  endfunction

  function automatic int ref_pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_din(input int i, input logic [DW-1:0] v);
    din[i*DW +: DW] = v;
  endtask

  task automatic do_single(input int i, input logic [DW-1:0] v);
    int n;
    n = 0;
    set_din(i, v);
    req[i] = 1'b1;
    tick();
    while (gnt == '0 && n < 6) begin
      tick();
      n++;
    end
    chk("sweep_gnt", 64'(gnt), 64'(oh(i)));
    chk("sweep_dec_a", 64'(dec_a), 64'(v));
    req[i] = 1'b0;
    tick();
    exp_slot[i] = seg7(v);
    chk("sweep_rv", 64'(rsp_valid), 64'(oh(i)));
    chk("sweep_data", 64'(rsp_data), 64'(exp_vec()));
  endtask

  initial begin
    int               ptr;
    int               pend;
    int               w;
    logic [OW-1:0]    pend_val;
    logic [NREQ-1:0]  prev_req;
    logic [NREQ-1:0]  expg;
    int               wait_cnt [NREQ];
    logic [DW-1:0]    rdin [NREQ];

    rst = 1'b0;
    req = '1;
    din = {4'h3, 4'h2, 4'h1, 4'h0};
    for (int i = 0; i < NREQ; i++) exp_slot[i] = '0;

    // reset held with all requests active
    repeat (3) tick();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rv", 64'(rsp_valid), 64'd0);
    chk("rst_dec_a", 64'(dec_a), 64'd0);
    chk("rst_data", 64'(rsp_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    tick();
    chk("first_setup_gnt", 64'(gnt), 64'd0);
    chk("first_setup_busy", 64'(busy), 64'd1);
    tick();

    // round robin with all requests held
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", 64'(gnt), 64'(oh(k % NREQ)));
      chk("rr_dec_a", 64'(dec_a), 64'(k % NREQ));
      chk("rr_busy", 64'(busy), 64'd1);
      tick();
      exp_slot[k % NREQ] = seg7(4'(k % NREQ));
      chk("rr_rv", 64'(rsp_valid), 64'(oh(k % NREQ)));
      chk("rr_gnt_gap", 64'(gnt), 64'd0);
      chk("rr_data", 64'(rsp_data), 64'(exp_vec()));
      chk("rr_busy2", 64'(busy), 64'd1);
      tick();
    end
    chk("rr_wrap_gnt", 64'(gnt), 64'(oh(1)));

    // reset in the CAPTURE cycle of requester 1
    rst = 1'b0;
    req = 4'b1010;
    tick();
    for (int i = 0; i < NREQ; i++) exp_slot[i] = '0;
    chk("midrst_rv", 64'(rsp_valid), 64'd0);
    chk("midrst_data", 64'(rsp_data), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_gnt", 64'(gnt), 64'd0);
    rst = 1'b1;
    tick();
    tick();
    chk("midrst_next_gnt", 64'(gnt), 64'(oh(1)));
    req = 4'b1000;
    tick();
    exp_slot[1] = seg7(4'h1);
    chk("midrst_rv1", 64'(rsp_valid), 64'(oh(1)));
    tick();
    chk("midrst_gnt3", 64'(gnt), 64'(oh(3)));
    req = '0;
    tick();
    exp_slot[3] = seg7(4'h3);
    chk("midrst_rv3", 64'(rsp_valid), 64'(oh(3)));
    chk("midrst_data2", 64'(rsp_data), 64'(exp_vec()));
    chk("midrst_idle", 64'(busy), 64'd0);

    // single request on requester 2
    set_din(2, 4'h9);
    req = 4'b0100;
    tick();
    chk("single_setup_gnt", 64'(gnt), 64'd0);
    chk("single_setup_busy", 64'(busy), 64'd1);
    tick();
    chk("single_gnt", 64'(gnt), 64'(oh(2)));
    chk("single_dec_a", 64'(dec_a), 64'h9);
    req = '0;
    tick();
    exp_slot[2] = seg7(4'h9);
    chk("single_rv", 64'(rsp_valid), 64'(oh(2)));
    chk("single_data", 64'(rsp_data), 64'(exp_vec()));
    chk("single_idle", 64'(busy), 64'd0);

    // after serving 2 the scan order is 3,0,1,2
    set_din(0, 4'h5);
    set_din(2, 4'hA);
    req = 4'b0101;
    tick();
    tick();
    chk("fair_first", 64'(gnt), 64'(oh(0)));
    req[0] = 1'b0;
    tick();
    exp_slot[0] = seg7(4'h5);
    chk("fair_rv0", 64'(rsp_valid), 64'(oh(0)));
    tick();
    chk("fair_second", 64'(gnt), 64'(oh(2)));
    chk("fair_dec_a", 64'(dec_a), 64'hA);
    req[2] = 1'b0;
    tick();
    exp_slot[2] = seg7(4'hA);
    chk("fair_rv2", 64'(rsp_valid), 64'(oh(2)));
    chk("fair_data", 64'(rsp_data), 64'(exp_vec()));

    // a winner still holding req in CAPTURE must not be granted again
    set_din(0, 4'h7);
    req = 4'b0001;
    tick();
    tick();
    chk("mask_gnt", 64'(gnt), 64'(oh(0)));
    tick();
    exp_slot[0] = seg7(4'h7);
    chk("mask_rv", 64'(rsp_valid), 64'(oh(0)));
    chk("mask_idle", 64'(busy), 64'd0);
    req = '0;
    tick();
    chk("mask_no_regnt", 64'(gnt), 64'd0);
    tick();
    chk("mask_no_regnt2", 64'(gnt), 64'd0);

    // every nibble on every requester
    for (int i = 0; i < NREQ; i++)
      for (int v = 0; v < 16; v++)
        do_single(i, 4'(v));

    // randomized traffic against the scoreboard
    rst = 1'b0;
    req = '0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      exp_slot[i] = '0;
      wait_cnt[i] = 0;
      rdin[i]     = '0;
    end
    chk("rnd_rst_data", 64'(rsp_data), 64'd0);
    ptr      = 0;
    pend     = -1;
    pend_val = '0;
    prev_req = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      if (pend >= 0) begin
        exp_slot[pend] = pend_val;
        chk("rnd_rv", 64'(rsp_valid), 64'(oh(pend)));
        pend = -1;
      end else begin
        chk("rnd_rv_quiet", 64'(rsp_valid), 64'd0);
      end
      chk("rnd_data", 64'(rsp_data), 64'(exp_vec()));
      chk("rnd_excl", 64'((gnt != '0) && (rsp_valid != '0)), 64'd0);
      w = -1;
      if (gnt != '0) begin
        w    = ref_pick(prev_req, ptr);
        expg = (w < 0) ? '0 : oh(w);
        chk("rnd_gnt", 64'(gnt), 64'(expg));
        if (w >= 0) begin
          chk("rnd_dec_a", 64'(dec_a), 64'(rdin[w]));
          pend_val    = seg7(rdin[w]);
          pend        = w;
          ptr         = (w + 1) % NREQ;
          req[w]      = 1'b0;
          wait_cnt[w] = 0;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          wait_cnt[i]++;
          chk("rnd_starve", 64'(wait_cnt[i] > BOUND), 64'd0);
          if (wait_cnt[i] > BOUND) wait_cnt[i] = 0;
        end else if (i != w && $urandom_range(0, 3) == 0) begin
          rdin[i]     = 4'($urandom);
          set_din(i, rdin[i]);
          req[i]      = 1'b1;
          wait_cnt[i] = 0;
        end
      end
      prev_req = req;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
